bec_la_ctrl: RTL and testbench
==============================

BEC_LA_CTRL -- requirements
Module: bec_la_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 16: width of command, data and operand words.
REQ-002 SHALL have parameter TIMEOUT, default 4096: maximum RUN cycles before abort.
REQ-003 SHALL have parameter PACE, default 2000: cycles between readback words.
REQ-004 SHALL have port wb_clk_i, input, 1: the single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port wb_rst_i, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port la_cmd, input, BITS: command opcode from la_data_in[63:48].
REQ-007 SHALL have port la_wdata, input, BITS: write data from la_data_in[47:32].
REQ-008 SHALL have port dp_op, output, 4*BITS: operand words 3..0, with word i at [BITS*i +: BITS].
REQ-009 SHALL have port dp_start, output, 1: one-cycle datapath start pulse.
REQ-010 SHALL have port dp_done, input, 1: datapath completion pulse.
REQ-011 SHALL have port dp_res, input, 2*BITS: datapath result, valid while dp_done=1.
REQ-012 SHALL have port la_rdata, output, BITS: readback word.
REQ-013 SHALL have port la_rvalid, output, 1: one-cycle pulse when la_rdata updates.
REQ-014 SHALL have port la_rdone, output, 1: one-cycle pulse after the last readback word.
REQ-015 SHALL have port state_o, output, 3: current state encoding, for LA observation.

Function
REQ-016 Command acceptance SHALL be edge-based: a command executes only in the cycle after la_cmd differs from its registered previous value. A held value never re-executes.
REQ-017 Opcodes SHALL be decoded as follows; all other values are ignored.
- 16'hAB00: ARM.
- 16'hA000..16'hA003: WR operand i = la_cmd[1:0].
- 16'hAB40: START.
- 16'hAB7F: ABORT.
REQ-018 The states SHALL be IDLE=0, LOAD=1, RUN=2, READ=3.
REQ-019 IDLE SHALL go to LOAD on ARM, clearing all operands to 0 in the same cycle.
REQ-020 In LOAD, WR SHALL write la_wdata into operand i; START SHALL assert dp_start for exactly one cycle and enter RUN.
REQ-021 START with unwritten operands SHALL be legal; those operands are 0.
REQ-022 RUN SHALL count cycles from 1.
- On dp_done: capture dp_res, set status 16'h00D0, enter READ.
- On the count reaching TIMEOUT with no dp_done: set status 16'h00EE, clear the result, enter READ.
- dp_done in the same cycle as the timeout: dp_done SHALL win.
REQ-023 READ SHALL emit 3 words, each PACE cycles apart, the first PACE cycles after entry: status, res[BITS-1:0], res[2*BITS-1:BITS]. Each word asserts la_rvalid for one cycle; la_rdata holds between words.
REQ-024 One cycle after the third word, la_rdone SHALL pulse and the block SHALL return to IDLE.
REQ-025 ABORT in any non-IDLE state SHALL enter IDLE next cycle, clear operands, and produce no la_rvalid or la_rdone. A pending dp_start is suppressed.
REQ-026 dp_done outside RUN SHALL be ignored.
REQ-027 WR or START outside LOAD SHALL be ignored; ARM outside IDLE SHALL be ignored.
REQ-028 The cycle counter SHALL be 16 bits, saturating, and SHALL clear on every state change.

Reset
REQ-029 While wb_rst_i=1, at the next edge the block SHALL set:
- state IDLE;
- dp_op, la_rdata, captured result and status to 0;
- dp_start, la_rvalid, la_rdone to 0;
- the previous-command register to 16'h0000.
REQ-030 Reset mid-RUN or mid-READ SHALL discard the operation with no further pulses.

Structure
REQ-031 Package bec_ctrl_pkg SHALL hold the opcode constants, state encodings and status codes D0/EE.
REQ-032 Sub-module pace_timer SHALL provide the shared cycle counter (clear, enable, terminal-count compare), used for both the RUN timeout and READ pacing.
REQ-033 Expected RTL size is 150-300 lines in total.

Verification (PACE=4, TIMEOUT=16 unless stated)
REQ-034 Normal run:
- stimulus: AB00; A000/0x1234; A001/0xBEEF; AB40; dp_done after 5 cycles with dp_res=0xCAFE_F00D.
- response: dp_op[31:0]=0xBEEF1234; one dp_start; rdata D0, F00D, CAFE at 4-cycle spacing; then la_rdone.
REQ-035 Timeout:
- stimulus: AB00, AB40, no dp_done.
- response: after 16 RUN cycles, rdata 00EE, 0000, 0000; then la_rdone.
REQ-036 Held command: la_cmd held at AB40 for 50 cycles → exactly one dp_start.
REQ-037 Abort:
- stimulus: AB7F issued during READ after the first word.
- response: IDLE next cycle; no further la_rvalid; no la_rdone; dp_op=0.
REQ-038 Race: dp_done in the timeout cycle → status D0 with the captured result.
REQ-039 Reset: wb_rst_i asserted in RUN → state_o=0 and all outputs 0 next cycle; a later dp_done is ignored.

Source files
------------

// File: rtl/bec_ctrl_pkg.sv
// bec_ctrl_pkg: shared constants and types for the logic-analyzer command
// controller. Holds the LA opcodes, FSM state encodings, readback status
// codes and a small opcode decoder used by the top level.
package bec_ctrl_pkg;

    // FSM states, exported unchanged on state_o for LA observation
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_READ = 3'd3
    } state_e;

    // LA command opcodes (WR uses the low two bits as operand index)
    localparam logic [15:0] OP_ARM   = 16'hAB00;
    localparam logic [15:0] OP_WR0   = 16'hA000;
    localparam logic [15:0] OP_START = 16'hAB40;
    localparam logic [15:0] OP_ABORT = 16'hAB7F;

    // Readback status words
    localparam logic [15:0] STAT_DONE = 16'h00D0;
    localparam logic [15:0] STAT_TMO  = 16'h00EE;

    // Width of the shared cycle counter
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_ARM   = 3'd1,
        CMD_WR    = 3'd2,
        CMD_START = 3'd3,
        CMD_ABORT = 3'd4
    } cmd_e;

    typedef struct packed {
        cmd_e       kind;
        logic [1:0] idx;
    } cmd_t;

    // Map a raw opcode to a command; unknown values decode to CMD_NONE.
    function automatic cmd_t decode_cmd(input logic [15:0] op);
        cmd_t c;
        c.kind = CMD_NONE;
        c.idx  = op[1:0];
        if (op == OP_ARM)                        c.kind = CMD_ARM;
        else if ({op[15:2], 2'b00} == OP_WR0)    c.kind = CMD_WR;
        else if (op == OP_START)                 c.kind = CMD_START;
        else if (op == OP_ABORT)                 c.kind = CMD_ABORT;
        return c;
    endfunction

endpackage

// File: rtl/bec_la_ctrl_pace_timer.sv
// pace_timer: 16-bit-style saturating cycle counter with synchronous clear,
// count enable and a terminal-count compare against a runtime value.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   clr          - force count to 0 next cycle (wins over en)
//   en           - increment (saturates at all-ones)
//   tc_val       - terminal value compared against the current count
//   tc           - high while count == tc_val
module pace_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/bec_la_ctrl.sv
// bec_la_ctrl: command controller driven from logic-analyzer pins. Commands
// are taken on a change of la_cmd, operands are loaded, a datapath run is
// started and supervised with a timeout, and status + 32-bit result are
// read back as three paced words.
// Ports:
//   wb_clk_i, wb_rst_i     - clock, synchronous active-high reset
//   la_cmd, la_wdata       - command opcode and write data
//   dp_op, dp_start        - operand words 3..0 and one-cycle start pulse
//   dp_done, dp_res        - datapath completion pulse and result
//   la_rdata, la_rvalid    - readback word and its one-cycle strobe
//   la_rdone               - pulse one cycle after the last readback word
//   state_o                - current FSM state
import bec_ctrl_pkg::*;

module bec_la_ctrl #(
    parameter int BITS    = 16,
    parameter int TIMEOUT = 4096,
    parameter int PACE    = 2000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [BITS-1:0]   la_cmd,
    input  logic [BITS-1:0]   la_wdata,
    output logic [4*BITS-1:0] dp_op,
    output logic              dp_start,
    input  logic              dp_done,
    input  logic [2*BITS-1:0] dp_res,
    output logic [BITS-1:0]   la_rdata,
    output logic              la_rvalid,
    output logic              la_rdone,
    output logic [2:0]        state_o
);

    // Timer compares against count-1: count 0 is the first cycle in a state.
    localparam logic [CNT_W-1:0] TMO_TC  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PACE_TC = CNT_W'(PACE - 1);

    state_e            state_q, state_d;
    logic [BITS-1:0]   prev_cmd_q;
    logic [4*BITS-1:0] ops_q, ops_d;
    logic [2*BITS-1:0] res_q, res_d;
    logic [BITS-1:0]   status_q, status_d;
    logic [BITS-1:0]   rdata_q, rdata_d;
    logic [1:0]        word_q, word_d;
    logic              start_q, start_d;
    logic              rvalid_q, rvalid_d;
    logic              rdone_q, rdone_d;

    cmd_t              cmd;
    logic              is_abort;
    logic              emit;
    logic              tmr_clr, tmr_en, tmr_tc;
    logic [CNT_W-1:0]  tmr_tcval;

    // Only a change of la_cmd is a command; a held value decodes to NONE.
    always_comb begin
        cmd = '0;
        if (la_cmd != prev_cmd_q)
            cmd = decode_cmd(16'(la_cmd));
    end

    assign is_abort = (cmd.kind == CMD_ABORT);

    // A readback word goes out on each terminal count until all three are sent.
    assign emit = (state_q == ST_READ) && tmr_tc && (word_q != 2'd3) && !is_abort;

    // Counter restarts on every state change and after each readback word.
    assign tmr_clr   = (state_d != state_q) || emit;
    assign tmr_en    = (state_q == ST_RUN) || (state_q == ST_READ);
    assign tmr_tcval = (state_q == ST_RUN) ? TMO_TC : PACE_TC;

    pace_timer #(.W(CNT_W)) u_timer (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .tc_val (tmr_tcval),
        .tc     (tmr_tc)
    );

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd.kind == CMD_ARM) state_d = ST_LOAD;
            ST_LOAD: begin
                if (is_abort)                     state_d = ST_IDLE;
                else if (cmd.kind == CMD_START)   state_d = ST_RUN;
            end
            ST_RUN: begin
                if (is_abort)                     state_d = ST_IDLE;
                else if (dp_done || tmr_tc)       state_d = ST_READ;
            end
            ST_READ: begin
                if (is_abort || (word_q == 2'd3)) state_d = ST_IDLE;
            end
            default:                              state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        ops_d    = ops_q;
        res_d    = res_q;
        status_d = status_q;
        rdata_d  = rdata_q;
        word_d   = word_q;
        start_d  = 1'b0;
        rvalid_d = 1'b0;
        rdone_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd.kind == CMD_ARM) ops_d = '0;
            end
            ST_LOAD: begin
                if (is_abort)
                    ops_d = '0;
                else if (cmd.kind == CMD_WR)
                    ops_d[BITS*cmd.idx +: BITS] = la_wdata;
                else if (cmd.kind == CMD_START)
                    start_d = 1'b1;
            end
            ST_RUN: begin
                // dp_done is checked first so it wins over a same-cycle timeout
                if (is_abort) begin
                    ops_d = '0;
                end else if (dp_done) begin
                    res_d    = dp_res;
                    status_d = BITS'(STAT_DONE);
                    word_d   = 2'd0;
                end else if (tmr_tc) begin
                    res_d    = '0;
                    status_d = BITS'(STAT_TMO);
                    word_d   = 2'd0;
                end
            end
            ST_READ: begin
                if (is_abort) begin
                    ops_d = '0;
                end else if (word_q == 2'd3) begin
                    rdone_d = 1'b1;
                end else if (emit) begin
                    rvalid_d = 1'b1;
                    word_d   = word_q + 2'd1;
                    case (word_q)
                        2'd0:    rdata_d = status_q;
                        2'd1:    rdata_d = res_q[BITS-1:0];
                        default: rdata_d = res_q[2*BITS-1:BITS];
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            prev_cmd_q <= '0;
            ops_q      <= '0;
            res_q      <= '0;
            status_q   <= '0;
            rdata_q    <= '0;
            word_q     <= '0;
            start_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            rdone_q    <= 1'b0;
        end else begin
            prev_cmd_q <= la_cmd;
            ops_q      <= ops_d;
            res_q      <= res_d;
            status_q   <= status_d;
            rdata_q    <= rdata_d;
            word_q     <= word_d;
            start_q    <= start_d;
            rvalid_q   <= rvalid_d;
            rdone_q    <= rdone_d;
        end
    end

    assign dp_op     = ops_q;
    assign dp_start  = start_q;
    assign la_rdata  = rdata_q;
    assign la_rvalid = rvalid_q;
    assign la_rdone  = rdone_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_bec_la_ctrl.sv
// Bench for bec_la_ctrl: scoreboard of expected readback words, pushed when
// the stimulus that determines them is driven and popped on each la_rvalid.
module tb_bec_la_ctrl;

    localparam int BITS    = 16;
    localparam int PACE    = 4;
    localparam int TIMEOUT = 16;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i;
    logic [BITS-1:0]   la_cmd, la_wdata;
    logic [4*BITS-1:0] dp_op;
    logic              dp_start, dp_done;
    logic [2*BITS-1:0] dp_res;
    logic [BITS-1:0]   la_rdata;
    logic              la_rvalid, la_rdone;
    logic [2:0]        state_o;

    bec_la_ctrl #(.BITS(BITS), .TIMEOUT(TIMEOUT), .PACE(PACE)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .la_cmd   (la_cmd),
        .la_wdata (la_wdata),
        .dp_op    (dp_op),
        .dp_start (dp_start),
        .dp_done  (dp_done),
        .dp_res   (dp_res),
        .la_rdata (la_rdata),
        .la_rvalid(la_rvalid),
        .la_rdone (la_rdone),
        .state_o  (state_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cnt = 0, rv_cnt = 0, rdone_cnt = 0;
    int word_no = 0, last_rv = 0, first_rv = 0;
    logic [BITS-1:0] sb[$];
    logic [BITS-1:0] exp_w;

    // One cycle: sample at the falling edge, scoreboard readback words.
    task automatic tick();
        @(negedge wb_clk_i);
        cyc++;
        if (dp_start) start_cnt++;
        if (la_rvalid) begin
            rv_cnt++;
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rvalid_unexpected: got word %h, expected no word", la_rdata);
            end else begin
                exp_w = sb.pop_front();
                if (la_rdata !== exp_w) begin
                    n_fail++;
                    $display("FAIL rdata: got %h, expected %h", la_rdata, exp_w);
                end
            end
            if (word_no > 0) begin
                n_chk++;
                if (cyc - last_rv != PACE) begin
                    n_fail++;
                    $display("FAIL rvalid_spacing: got %0d, expected %0d", cyc - last_rv, PACE);
                end
            end else begin
                first_rv = cyc;
            end
            last_rv = cyc;
            word_no++;
        end
        if (la_rdone) begin
            rdone_cnt++;
            n_chk++;
            if (!(word_no == 3 && last_rv == cyc - 1)) begin
                n_fail++;
                $display("FAIL rdone_timing: got words=%0d gap=%0d, expected words=3 gap=1",
                         word_no, cyc - last_rv);
            end
            word_no = 0;
        end
    endtask

    task automatic issue(input logic [15:0] op, input logic [15:0] wd);
        la_cmd   = op;
        la_wdata = wd;
        tick();
    endtask

    task automatic wait_rdone(input int budget);
        int base, k;
        base = rdone_cnt;
        k = 0;
        while (rdone_cnt == base && k < budget) begin
            tick();
            k++;
        end
        n_chk++;
        if (rdone_cnt == base) begin
            n_fail++;
            $display("FAIL rdone_wait: got no la_rdone, expected one within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        int s0;
        wb_rst_i = 1'b1;
        repeat (3) tick();
        n_chk++;
        if ({state_o, dp_op, dp_start, la_rvalid, la_rdone, la_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got state=%0d op=%h st=%b rv=%b rd=%b rdata=%h, expected all 0",
                     state_o, dp_op, dp_start, la_rvalid, la_rdone, la_rdata);
        end
        wb_rst_i = 1'b0;
        tick();
        s0 = start_cnt;
        issue(16'hA000, 16'hFFFF);
        issue(16'hAB40, 16'h0000);
        tick();
        n_chk++;
        if (dp_op !== '0 || state_o !== 3'd0 || start_cnt != s0) begin
            n_fail++;
            $display("FAIL idle_ignore: got op=%h state=%0d starts=%0d, expected op=0 state=0 starts=0",
                     dp_op, state_o, start_cnt - s0);
        end
    endtask

    task automatic test_normal();
        int s0, e;
        word_no = 0;
        issue(16'hAB00, 16'h0000);
        n_chk++;
        if (state_o !== 3'd1 || dp_op !== '0) begin
            n_fail++;
            $display("FAIL arm: got state=%0d op=%h, expected state=1 op=0", state_o, dp_op);
        end
        issue(16'hA000, 16'h1234);
        issue(16'hA001, 16'hBEEF);
        issue(16'hAB00, 16'h0000);
        n_chk++;
        if (dp_op !== 64'h0000_0000_BEEF_1234 || state_o !== 3'd1) begin
            n_fail++;
            $display("FAIL load_ops: got op=%h state=%0d, expected op=00000000beef1234 state=1",
                     dp_op, state_o);
        end
        s0 = start_cnt;
        issue(16'hAB40, 16'h0000);
        n_chk++;
        if (dp_start !== 1'b1 || state_o !== 3'd2) begin
            n_fail++;
            $display("FAIL start: got dp_start=%b state=%0d, expected 1 and 2", dp_start, state_o);
        end
        repeat (4) tick();
        dp_done = 1'b1;
        dp_res  = 32'hCAFE_F00D;
        sb.push_back(16'h00D0);
        sb.push_back(16'hF00D);
        sb.push_back(16'hCAFE);
        tick();
        dp_done = 1'b0;
        dp_res  = '0;
        e = cyc;
        n_chk++;
        if (state_o !== 3'd3) begin
            n_fail++;
            $display("FAIL enter_read: got state=%0d, expected 3", state_o);
        end
        wait_rdone(60);
        n_chk++;
        if (first_rv - e != PACE) begin
            n_fail++;
            $display("FAIL first_word_latency: got %0d, expected %0d", first_rv - e, PACE);
        end
        n_chk++;
        if (start_cnt - s0 != 1 || sb.size() != 0 || state_o !== 3'd0) begin
            n_fail++;
            $display("FAIL normal_end: got starts=%0d left=%0d state=%0d, expected 1 0 0",
                     start_cnt - s0, sb.size(), state_o);
        end
    endtask

    task automatic test_timeout();
        int r1, k;
        word_no = 0;
        issue(16'hAB00, 16'h0000);
        sb.push_back(16'h00EE);
        sb.push_back(16'h0000);
        sb.push_back(16'h0000);
        issue(16'hAB40, 16'h0000);
        r1 = cyc;
        k = 0;
        while (state_o !== 3'd3 && k < 40) begin
            tick();
            k++;
        end
        n_chk++;
        if (cyc - r1 != TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d RUN cycles, expected %0d", cyc - r1, TIMEOUT);
        end
        wait_rdone(60);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_words: got %0d words missing, expected 0", sb.size());
        end
    endtask

    task automatic test_held();
        int s0, d0;
        word_no = 0;
        issue(16'hAB00, 16'h0000);
        sb.push_back(16'h00EE);
        sb.push_back(16'h0000);
        sb.push_back(16'h0000);
        s0 = start_cnt;
        d0 = rdone_cnt;
        la_cmd = 16'hAB40;
        repeat (50) tick();
        n_chk++;
        if (start_cnt - s0 != 1 || rdone_cnt - d0 != 1 || state_o !== 3'd0) begin
            n_fail++;
            $display("FAIL held_cmd: got starts=%0d rdones=%0d state=%0d, expected 1 1 0",
                     start_cnt - s0, rdone_cnt - d0, state_o);
        end
    endtask

    task automatic test_abort();
        int v0, v1, d0, k;
        word_no = 0;
        issue(16'hAB00, 16'h0000);
        issue(16'hA002, 16'h5555);
        n_chk++;
        if (dp_op[47:32] !== 16'h5555) begin
            n_fail++;
            $display("FAIL op2_write: got %h, expected 5555", dp_op[47:32]);
        end
        issue(16'hAB40, 16'h0000);
        tick();
        dp_done = 1'b1;
        dp_res  = 32'h1111_2222;
        sb.push_back(16'h00D0);
        tick();
        dp_done = 1'b0;
        v0 = rv_cnt;
        k = 0;
        while (rv_cnt == v0 && k < 20) begin
            tick();
            k++;
        end
        n_chk++;
        if (rv_cnt == v0) begin
            n_fail++;
            $display("FAIL abort_first_word: got no word, expected one within 20 cycles");
        end
        issue(16'hAB7F, 16'h0000);
        n_chk++;
        if (state_o !== 3'd0 || dp_op !== '0) begin
            n_fail++;
            $display("FAIL abort_state: got state=%0d op=%h, expected 0 and 0", state_o, dp_op);
        end
        v1 = rv_cnt;
        d0 = rdone_cnt;
        repeat (20) tick();
        n_chk++;
        if (rv_cnt != v1 || rdone_cnt != d0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: got words=%0d rdones=%0d left=%0d, expected 0 0 0",
                     rv_cnt - v1, rdone_cnt - d0, sb.size());
        end
    endtask

    task automatic test_race();
        int r1;
        word_no = 0;
        issue(16'hAB00, 16'h0000);
        issue(16'hA003, 16'h00AA);
        n_chk++;
        if (dp_op !== 64'h00AA_0000_0000_0000) begin
            n_fail++;
            $display("FAIL op3_write: got %h, expected 00aa000000000000", dp_op);
        end
        issue(16'hAB40, 16'h0000);
        r1 = cyc;
        repeat (TIMEOUT - 1) tick();
        n_chk++;
        if (state_o !== 3'd2) begin
            n_fail++;
            $display("FAIL race_prerun: got state=%0d, expected 2", state_o);
        end
        dp_done = 1'b1;
        dp_res  = 32'h5A5A_A5A5;
        sb.push_back(16'h00D0);
        sb.push_back(16'hA5A5);
        sb.push_back(16'h5A5A);
        tick();
        dp_done = 1'b0;
        dp_res  = '0;
        n_chk++;
        if (state_o !== 3'd3 || cyc - r1 != TIMEOUT) begin
            n_fail++;
            $display("FAIL race_read: got state=%0d after %0d, expected 3 after %0d",
                     state_o, cyc - r1, TIMEOUT);
        end
        wait_rdone(60);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL race_words: got %0d words missing, expected 0", sb.size());
        end
    endtask

    task automatic test_rst_run();
        int s0, v0, d0;
        word_no = 0;
        issue(16'hAB00, 16'h0000);
        issue(16'hA001, 16'h7777);
        issue(16'hAB40, 16'h0000);
        repeat (3) tick();
        wb_rst_i = 1'b1;
        tick();
        n_chk++;
        if ({state_o, dp_op, dp_start, la_rvalid, la_rdone, la_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_in_run: got state=%0d op=%h st=%b rv=%b rd=%b rdata=%h, expected all 0",
                     state_o, dp_op, dp_start, la_rvalid, la_rdone, la_rdata);
        end
        wb_rst_i = 1'b0;
        s0 = start_cnt;
        v0 = rv_cnt;
        d0 = rdone_cnt;
        dp_done = 1'b1;
        dp_res  = 32'hFFFF_0000;
        tick();
        dp_done = 1'b0;
        repeat (20) tick();
        n_chk++;
        if (state_o !== 3'd0 || rv_cnt != v0 || rdone_cnt != d0 || start_cnt != s0) begin
            n_fail++;
            $display("FAIL reset_discard: got state=%0d words=%0d rdones=%0d starts=%0d, expected 0 0 0 0",
                     state_o, rv_cnt - v0, rdone_cnt - d0, start_cnt - s0);
        end
    endtask

    initial begin
        wb_rst_i = 1'b1;
        la_cmd   = '0;
        la_wdata = '0;
        dp_done  = 1'b0;
        dp_res   = '0;
        test_reset();
        test_normal();
        test_timeout();
        test_held();
        test_abort();
        test_race();
        test_rst_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
